spart_rx: RTL

- Receive half of the SPART serial port: oversampled UART receiver with a small receive FIFO.
- Sits directly downstream of the serial RX pin. It consumes the 8N1 frames that the bench's UART send task drives, and presents bytes to the SPART bus interface, which pops them on a databus read.
- Assumes a 50 MHz system clock. The bit period is given in clock cycles by the programmed baud divisor: 434 gives 115200 baud, 5208 gives 9600 baud.

---
 rtl/spart_rx.sv | 133 +++++++++++++
 1 files changed

// File: rtl/spart_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spart_rx : oversampled 8N1 UART receiver with a small receive FIFO       |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module spart_rx #(
  parameter int DB_W       = 13,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rxd,
  input  logic [DB_W-1:0]               baud_div,
  input  logic                          rx_rd,
  input  logic                          err_clr,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          frame_err,
  output logic                          overrun,
  output logic                          busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state_q;
  logic            s1_q, rx_s_q, rx_p_q;
  logic [DB_W-1:0] div_q, tmr_q;
  logic [2:0]      bitcnt_q;
  logic [7:0]      shift_q;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [CW-1:0]   wr_q, rd_q, rd_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;

  logic            w_expire, w_pop, w_full, w_stop_fire;
  logic            w_push, w_fe_set, w_ov_set;
  logic [CW-1:0]   w_count;

  assign w_count     = wr_q - rd_q;
  assign w_full      = (w_count == CW'(FIFO_DEPTH));
  assign w_pop       = rx_rd && (w_count != '0);
  assign w_expire    = (tmr_q == '0);
  assign w_stop_fire = (state_q == STOP) && w_expire;
  // A pop in the stop-sample cycle frees the slot the new byte needs.
  assign w_push      = w_stop_fire && rx_s_q && (!w_full || w_pop);
  assign w_ov_set    = w_stop_fire && rx_s_q && w_full && !w_pop;
  assign w_fe_set    = w_stop_fire && !rx_s_q;

  assign rd_d        = rd_q + CW'(w_pop);
  assign frame_err_d = w_fe_set || (frame_err_q && !err_clr);
  assign overrun_d   = w_ov_set || (overrun_q && !err_clr);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      s1_q        <= 1'b1;
      rx_s_q      <= 1'b1;
      rx_p_q      <= 1'b1;
      div_q       <= '0;
      tmr_q       <= '0;
      bitcnt_q    <= '0;
      shift_q     <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      s1_q        <= rxd;
      rx_s_q      <= s1_q;
      rx_p_q      <= rx_s_q;
      rd_q        <= rd_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      if (w_push) begin
        mem_q[wr_q[AW-1:0]] <= shift_q;
        wr_q                <= wr_q + CW'(1);
      end
      if (!w_expire) tmr_q <= tmr_q - DB_W'(1);

      case (state_q)
        IDLE: begin
          if (rx_p_q && !rx_s_q) begin
            tmr_q   <= baud_div >> 1;
            div_q   <= baud_div;
            state_q <= START;
          end
        end
        START: begin
          if (w_expire) begin
            if (!rx_s_q) begin
              tmr_q    <= div_q - DB_W'(1);
              bitcnt_q <= '0;
              state_q  <= DATA;
            end else begin
              state_q  <= IDLE;
            end
          end
        end
        DATA: begin
          if (w_expire) begin
            shift_q  <= {rx_s_q, shift_q[7:1]};
            tmr_q    <= div_q - DB_W'(1);
            bitcnt_q <= bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) state_q <= STOP;
          end
        end
        STOP: begin
          if (w_expire) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rx_data   = mem_q[rd_q[AW-1:0]];
  assign rx_valid  = (w_count != '0);
  assign rx_count  = w_count;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != IDLE);

endmodule
`default_nettype wire
